// File: rtl/tmu2_geninterp_pkg.sv
// Shared definitions for the TMU2 generic interpolator.
// FSM state encodings are kept as 1-bit constants so older users of this block still match.
package tmu2_geninterp_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

endpackage

// File: rtl/tmu2_geninterp_chan.sv
// One interpolated channel: latched step parameters, error accumulator and point register.
// It steps by q plus a ±1 correction each time step_en is high, and reloads when load_en is high.
module tmu2_geninterp_chan #(
  parameter int WIDTH = 18
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load_en,
  input  logic             step_en,
  input  logic [WIDTH-1:0] init,
  input  logic             positive,
  input  logic [WIDTH-2:0] q,
  input  logic [WIDTH-2:0] r,
  input  logic [WIDTH-2:0] divisor,
  output logic [WIDTH-1:0] o
);

  logic                    pos_q;
  logic [WIDTH-2:0]        q_q;
  logic [WIDTH-2:0]        r_q;
  logic [WIDTH-2:0]        div_q;
  logic signed [WIDTH-1:0] err;

  logic signed [WIDTH:0]   e_sum;
  logic signed [WIDTH:0]   half;
  logic signed [WIDTH:0]   e_next;
  logic                    corr;
  logic [WIDTH-1:0]        mag;
  logic [WIDTH-1:0]        o_next;

  // err + r can exceed the WIDTH-bit range before correction, so compare one bit wider.
  always_comb begin
    e_sum  = $signed({err[WIDTH-1], err}) + $signed({2'b00, r_q});
    half   = $signed({3'b000, div_q[WIDTH-2:1]});
    corr   = (e_sum > half);
    e_next = corr ? (e_sum - $signed({2'b00, div_q})) : e_sum;
    mag    = {1'b0, q_q} + {{(WIDTH-1){1'b0}}, corr};
    o_next = pos_q ? (o + mag) : (o - mag);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pos_q <= 1'b0;
      q_q   <= '0;
      r_q   <= '0;
      div_q <= '0;
      err   <= '0;
      o     <= '0;
    end else if (load_en) begin
      pos_q <= positive;
      q_q   <= q;
      r_q   <= r;
      div_q <= divisor;
      err   <= '0;
      o     <= init;
    end else if (step_en) begin
      err   <= e_next[WIDTH-1:0];
      o     <= o_next;
    end
  end

endmodule

// File: rtl/tmu2_geninterp_multi.sv
// Multi-channel Bresenham interpolator: emits count+1 points per job over a stb/ack interface.
// First point appears one cycle after load; a stalled point holds until acknowledged.
module tmu2_geninterp_multi
  import tmu2_geninterp_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 18,
  parameter int CW       = 11
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        load,
  output logic                        busy,
  input  logic [CW-1:0]               count,
  input  logic [CHANNELS*WIDTH-1:0]   init,
  input  logic [CHANNELS-1:0]         positive,
  input  logic [CHANNELS*(WIDTH-1)-1:0] q,
  input  logic [CHANNELS*(WIDTH-1)-1:0] r,
  input  logic [CHANNELS*(WIDTH-1)-1:0] divisor,
  output logic                        pipe_stb_o,
  input  logic                        pipe_ack_i,
  output logic [CHANNELS*WIDTH-1:0]   o,
  output logic                        last_o
);

  logic          state;
  logic [CW-1:0] remaining;
  logic          fire;
  logic          load_en;
  logic          step_en;

  assign busy       = (state == STATE_RUN);
  assign pipe_stb_o = busy;
  assign last_o     = busy && (remaining == '0);
  assign fire       = pipe_stb_o && pipe_ack_i;
  assign load_en    = !busy && load;
  assign step_en    = fire && (remaining != '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= STATE_IDLE;
      remaining <= '0;
    end else if (load_en) begin
      state     <= STATE_RUN;
      remaining <= count;
    end else if (fire) begin
      if (remaining == '0) state <= STATE_IDLE;
      else                 remaining <= remaining - CW'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    tmu2_geninterp_chan #(.WIDTH(WIDTH)) u_chan (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .load_en   (load_en),
      .step_en   (step_en),
      .init      (init[k*WIDTH +: WIDTH]),
      .positive  (positive[k]),
      .q         (q[k*(WIDTH-1) +: (WIDTH-1)]),
      .r         (r[k*(WIDTH-1) +: (WIDTH-1)]),
      .divisor   (divisor[k*(WIDTH-1) +: (WIDTH-1)]),
      .o         (o[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_tmu2_geninterp_multi.sv
// Bench for tmu2_geninterp_multi: directed and random jobs against a closed-form Bresenham model.
module tb_tmu2_geninterp_multi;

  localparam int CH = 2;
  localparam int W  = 18;
  localparam int CW = 11;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst_n = 1'b0;
  logic                  load = 1'b0;
  logic                  busy;
  logic [CW-1:0]         count = '0;
  logic [CH*W-1:0]       init = '0;
  logic [CH-1:0]         positive = '0;
  logic [CH*(W-1)-1:0]   q = '0;
  logic [CH*(W-1)-1:0]   r = '0;
  logic [CH*(W-1)-1:0]   divisor = '0;
  logic                  pipe_stb_o;
  logic                  pipe_ack_i = 1'b0;
  logic [CH*W-1:0]       o;
  logic                  last_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 sys_clk = ~sys_clk;

  tmu2_geninterp_multi #(.CHANNELS(CH), .WIDTH(W), .CW(CW)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .load       (load),
    .busy       (busy),
    .count      (count),
    .init       (init),
    .positive   (positive),
    .q          (q),
    .r          (r),
    .divisor    (divisor),
    .pipe_stb_o (pipe_stb_o),
    .pipe_ack_i (pipe_ack_i),
    .o          (o),
    .last_o     (last_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Point n of a channel: after n steps the number of +1 corrections is the
  // smallest C with n*r - d*C <= floor(d/2); the value is init +/- (n*q + C).
  function automatic logic [W-1:0] expect_pt(input logic [W-1:0] i0, input bit pos,
                                             input longint qv, input longint rv,
                                             input longint dv, input longint n);
    longint a, c, delta, v;
    c = 0;
    if (dv != 0) begin
      a = n * rv - dv / 2;
      c = (a >= 0) ? (a + dv - 1) / dv : -((-a) / dv);
    end
    delta = n * qv + c;
    v = pos ? (longint'($signed(i0)) + delta) : (longint'($signed(i0)) - delta);
    return v[W-1:0];
  endfunction

  // ack_mode: 0 = always ack, 1 = pattern 1,0,0,..., 2 = random
  task automatic run_job(input int cnt, input logic [CH*W-1:0] init_v, input logic [CH-1:0] pos_v,
                         input logic [CH*(W-1)-1:0] q_v, input logic [CH*(W-1)-1:0] r_v,
                         input logic [CH*(W-1)-1:0] d_v, input int ack_mode, input bit inject);
    int  n;
    int  cycles;
    bit  ack;
    @(negedge sys_clk);
    chk("idle_busy", busy, 0);
    chk("idle_stb", pipe_stb_o, 0);
    count = CW'(cnt); init = init_v; positive = pos_v; q = q_v; r = r_v; divisor = d_v;
    load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0;
    n = 0; cycles = 0;
    while (n <= cnt && cycles < 5000) begin
      chk("stb", pipe_stb_o, 1);
      chk("busy", busy, 1);
      chk("last", last_o, (n == cnt));
      for (int k = 0; k < CH; k++)
        chk($sformatf("o_ch%0d_pt%0d", k, n), o[k*W +: W],
            expect_pt(init_v[k*W +: W], pos_v[k], longint'(q_v[k*(W-1) +: (W-1)]),
                      longint'(r_v[k*(W-1) +: (W-1)]), longint'(d_v[k*(W-1) +: (W-1)]), n));
      load = inject && (cycles == 2);
      init = load ? ~init_v : init_v;
      case (ack_mode)
        0:       ack = 1'b1;
        1:       ack = (cycles % 3 == 0);
        default: ack = ($urandom_range(0, 1) == 1);
      endcase
      pipe_ack_i = ack;
      @(negedge sys_clk);
      if (ack) n++;
      cycles++;
    end
    load = 1'b0;
    pipe_ack_i = 1'b0;
    chk("job_points", n, cnt + 1);
    chk("done_stb", pipe_stb_o, 0);
    chk("done_busy", busy, 0);
    chk("done_last", last_o, 0);
    chk("done_o_hold_ch0", o[W-1:0],
        expect_pt(init_v[W-1:0], pos_v[0], longint'(q_v[W-2:0]), longint'(r_v[W-2:0]),
                  longint'(d_v[W-2:0]), cnt));
  endtask

  function automatic logic [W-2:0] f17(input int v);
    return v[W-2:0];
  endfunction

  function automatic logic [W-1:0] f18(input int v);
    return v[W-1:0];
  endfunction

  initial begin
    logic [CH*W-1:0]     iv;
    logic [CH-1:0]       pv;
    logic [CH*(W-1)-1:0] qv, rv, dv;
    int d;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_stb", pipe_stb_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_o", o, 0);
    sys_rst_n = 1'b1;

    // Basic stepping: ch0 100,102,105,107,109,112; ch1 descending sequence.
    iv = {f18(-7), f18(100)}; pv = 2'b01;
    qv = {f17(5), f17(2)}; rv = {f17(2), f17(1)}; dv = {f17(7), f17(3)};
    run_job(5, iv, pv, qv, rv, dv, 0, 1'b0);

    // Negative direction: 0,0,-1,-1,-2.
    iv = {f18(0), f18(0)}; pv = 2'b00;
    qv = {f17(0), f17(0)}; rv = {f17(1), f17(1)}; dv = {f17(2), f17(2)};
    run_job(4, iv, pv, qv, rv, dv, 0, 1'b0);

    // Backpressure on the first scenario.
    iv = {f18(-7), f18(100)}; pv = 2'b01;
    qv = {f17(5), f17(2)}; rv = {f17(2), f17(1)}; dv = {f17(7), f17(3)};
    run_job(5, iv, pv, qv, rv, dv, 1, 1'b0);

    // Wrap on ch0, pure-q descent on ch1.
    iv = {f18(-5), f18(131071)}; pv = 2'b01;
    qv = {f17(3), f17(1)}; rv = '0; dv = '0;
    run_job(1, iv, pv, qv, rv, dv, 0, 1'b0);

    // Single-point job.
    iv = {f18(1234), f18(-999)}; pv = 2'b10;
    qv = {f17(9), f17(4)}; rv = {f17(1), f17(2)}; dv = {f17(5), f17(5)};
    run_job(0, iv, pv, qv, rv, dv, 0, 1'b0);

    // Load while running is ignored.
    iv = {f18(-7), f18(100)}; pv = 2'b01;
    qv = {f17(5), f17(2)}; rv = {f17(2), f17(1)}; dv = {f17(7), f17(3)};
    run_job(5, iv, pv, qv, rv, dv, 2, 1'b1);

    // Random jobs.
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < CH; k++) begin
        iv[k*W +: W] = W'($urandom);
        pv[k] = $urandom_range(0, 1) == 1;
        qv[k*(W-1) +: (W-1)] = (W-1)'($urandom_range(0, (j % 2) ? 131071 : 40));
        d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, (j % 2) ? 131071 : 60));
        dv[k*(W-1) +: (W-1)] = f17(d);
        rv[k*(W-1) +: (W-1)] = (d == 0) ? '0 : f17(int'($urandom_range(0, d - 1)));
      end
      run_job(int'($urandom_range(0, 24)), iv, pv, qv, rv, dv, j % 3, 1'b0);
    end

    // Asynchronous reset in the middle of a job.
    @(negedge sys_clk);
    iv = {f18(50), f18(60)}; init = iv; positive = 2'b11;
    q = {f17(1), f17(1)}; r = '0; divisor = '0; count = CW'(10);
    load = 1'b1;
    @(negedge sys_clk);
    load = 1'b0; pipe_ack_i = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("pre_rst_stb", pipe_stb_o, 1);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_stb", pipe_stb_o, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_o", o, 0);
    chk("mid_rst_last", last_o, 0);
    pipe_ack_i = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("post_rst_stb", pipe_stb_o, 0);
    iv = {f18(-300), f18(77)}; pv = 2'b10;
    qv = {f17(11), f17(3)}; rv = {f17(4), f17(2)}; dv = {f17(9), f17(5)};
    run_job(6, iv, pv, qv, rv, dv, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
